spi_master_rw: RTL and testbench
================================

Name: spi_master_rw

Overview:
- Single-clock SPI master that issues addressed register transactions to the board's SPI slave blocks.
- The slaves are register read-back slaves: address byte with 7-bit address, followed by Nbit of data.
- The master generates cs/sclk/mosi from clk, shifts out a command byte then Nbit data, and captures Nbit read data from miso.
- Sits between the control FSM/CPU bridge and the slave chain on the same clk.

Parameters:
- Nbit, 8, data field width (bits after the command byte).
- CLK_DIV, 4, clk cycles per sclk half-period; legal range 4..255.
- CS_SETUP, 4, clk cycles cs low before the first sclk rise; minimum 3.
- ADR_GAP, 4, clk cycles sclk held low between the command byte and the data field; minimum 3.
- CS_HOLD, 2, clk cycles cs low after the last sclk fall.
- CS_IDLE, 4, minimum clk cycles cs high between transactions.

Ports:
- clk  in  1  system clock; also clocks the slaves.
- rst  in  1  asynchronous reset, active-low.
- start  in  1  request pulse; accepted only when busy=0.
- rw  in  1  command bit7: 0 = read, 1 = write.
- adr  in  7  slave address, command bits 6:0.
- wdata  in  Nbit  write data, MSB first.
- busy  out  1  transaction in progress, including the CS_IDLE gap.
- done  out  1  one-cycle pulse at end of transaction.
- rdata  out  Nbit  captured read data.
- sclk  out  1  SPI clock, idle low (mode 0).
- mosi  out  1  serial data out.
- miso  in  1  serial data in, same clk domain as the slaves.
- cs  out  1  chip select, active low.

Behaviour:
- Reset (rst=0, async): cs=1, sclk=0, mosi=0, busy=0, done=0, rdata=0, FSM=IDLE. Applies immediately, including mid-transaction; cs rises the same instant.
- Start acceptance:
  - start=1 with busy=0 at edge T latches rw, adr, wdata into a shift register {rw, adr, wdata}, MSB first.
  - busy=1 and cs=0 from T+1.
  - start while busy is ignored; no queueing.
- FSM: IDLE -> SETUP -> CMD -> GAP -> DATA -> HOLD -> IDLE_GAP -> IDLE.
- SETUP: CS_SETUP cycles with sclk=0; mosi=rw (bit7) from entry.
- Bit timing:
  - Each bit is a CLK_DIV-cycle low half followed by a CLK_DIV-cycle high half.
  - mosi updates on the cycle sclk falls; for the first bit of each field, on entry to the low half.
  - sclk rises after the low half.
- CMD: 8 bits, MSB (bit7) first; ends after the 8th high half with sclk=0.
- GAP: ADR_GAP cycles, sclk=0, mosi=first wdata bit. This lets the slave evaluate its address match before the first data edge.
- DATA: Nbit bits.
  - Read (rw=0): mosi=0 throughout DATA; miso is registered in the clk cycle sclk goes 0->1 and shifted into rx_shift LSB-first-in (MSB received first).
  - Write (rw=1): wdata is shifted out MSB first; miso is ignored.
- HOLD: CS_HOLD cycles, sclk=0, cs=0.
- End of transaction (cs -> 1): done=1 for exactly one cycle. On a read, rdata<=rx_shift in the same cycle; on a write, rdata is unchanged.
- IDLE_GAP: CS_IDLE cycles, cs=1, busy=1; then IDLE, busy=0.
- Duration: start edge to done = 1+CS_SETUP+16*CLK_DIV+ADR_GAP+2*Nbit*CLK_DIV+CS_HOLD cycles. Defaults: 1+4+64+4+64+2 = 139.
- Non-matching slave: a slave that does not match the address leaves miso high. A read from an absent address therefore returns all ones, which is legal and not flagged.
- Counters: the divider counter is 8 bits; the bit counter is clog2(Nbit+1) wide. No wrap inside a field.

Decomposition:
- Shared package spi_pkg:
  - FSM state enum.
  - CMD_RW_BIT=7, ADR_W=7, CMD_W=8.
  - Minimum-timing constants (3) for parameter assertions.
- One sub-module: spi_sclk_gen. Holds the divider counter; produces sclk, rise_stb and fall_stb when enabled; output is 0 when disabled.

Test Plan (Nbit=8, CLK_DIV=4 unless noted; bench uses a behavioural model of the existing slave, address 1, inport=0xA5):
1. Read adr=1, rw=0 -> mosi command byte 0x01; rdata=0xA5; done high exactly 139 cycles after the start edge, for 1 cycle.
2. Write adr=0x12, wdata=0x3C, rw=1 -> monitor captures 0x92 then 0x3C on sclk rises; rdata unchanged from the previous value; cs high afterwards.
3. Read adr=5 (no slave match) -> rdata=0xFF; no protocol error.
4. start pulsed again at cycles 10 and 100 of an active transaction -> ignored; exactly one done; next start accepted only when busy=0.
5. rst=0 asserted at cycle 50 of a read -> cs=1, sclk=0, busy=0 immediately; after release, a fresh read of adr=1 returns 0xA5.
6. Nbit=16, CLK_DIV=6, slave inport=0xBEEF, back-to-back reads -> each returns 0xBEEF; cs high for ≥4 cycles between transactions.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI register-access master.
// Holds the transaction FSM state encoding, the command byte layout and the
// timing limits that the master checks its parameters against.
package spi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_CMD,
    ST_GAP,
    ST_DATA,
    ST_HOLD,
    ST_IDLE_GAP
  } spi_state_e;

  // Command byte: bit 7 = rw (1 = write), bits 6:0 = slave address
  localparam int CMD_RW_BIT = 7;
  localparam int ADR_W      = 7;
  localparam int CMD_W      = 8;

  // Timing limits in clk cycles
  localparam int MIN_CS_SETUP = 3;
  localparam int MIN_ADR_GAP  = 3;
  localparam int MIN_CLK_DIV  = 4;
  localparam int MAX_CLK_DIV  = 255;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/spi_master_rw_if.sv
// Bus bundle between the requesting logic, the SPI master and the slave chain.
//   start/rw/adr/wdata : request side, driven by the requester
//   busy/done/rdata    : status side, driven by the master
//   sclk/mosi/cs       : SPI lines driven by the master
//   miso               : SPI line driven by the slave chain
// Nbit must match the Nbit of the master connected to it.
interface spi_master_rw_if
  import spi_pkg::*;
#(
  parameter int Nbit = 8
);
  logic             start;
  logic             rw;
  logic [ADR_W-1:0] adr;
  logic [Nbit-1:0]  wdata;
  logic             busy;
  logic             done;
  logic [Nbit-1:0]  rdata;
  logic             sclk;
  logic             mosi;
  logic             miso;
  logic             cs;

  modport master (
    input  start, rw, adr, wdata, miso,
    output busy, done, rdata, sclk, mosi, cs
  );

  modport slave (
    output start, rw, adr, wdata, miso,
    input  busy, done, rdata, sclk, mosi, cs
  );
endinterface

// File: rtl/spi_sclk_gen.sv
// SPI clock generator (mode 0, idle low).
//   clk      : system clock
//   rst      : asynchronous reset, active-low
//   en       : run the divider; when low the counter clears and sclk is 0
//   sclk     : registered SPI clock, CLK_DIV clk cycles per half-period
//   rise_stb : high in the clk cycle whose closing edge takes sclk 0->1
//   fall_stb : high in the clk cycle whose closing edge takes sclk 1->0
module spi_sclk_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic sclk,
  output logic rise_stb,
  output logic fall_stb
);

  logic [7:0] div_cnt;
  logic       half_end;

  assign half_end = en && (div_cnt == 8'(CLK_DIV - 1));
  assign rise_stb = half_end && !sclk;
  assign fall_stb = half_end &&  sclk;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt <= 8'd0;
      sclk    <= 1'b0;
    end else if (!en) begin
      div_cnt <= 8'd0;
      sclk    <= 1'b0;
    end else if (half_end) begin
      div_cnt <= 8'd0;
      sclk    <= ~sclk;
    end else begin
      div_cnt <= div_cnt + 8'd1;
    end
  end

endmodule

// File: rtl/spi_master_rw.sv
// SPI master for addressed register reads/writes to register read-back slaves.
// A transaction is a command byte {rw, adr[6:0]} followed by an Nbit data
// field, both MSB first, in SPI mode 0.
//   clk : system clock (shared with the slaves)
//   rst : asynchronous reset, active-low
//   bus : spi_master_rw_if master modport
//         start/rw/adr/wdata in, busy/done/rdata out, sclk/mosi/cs out, miso in
// Start edge to done = 1 + CS_SETUP + 16*CLK_DIV + ADR_GAP + 2*Nbit*CLK_DIV
// + CS_HOLD cycles; busy stays high for a further CS_IDLE cycles with cs high.
module spi_master_rw
  import spi_pkg::*;
#(
  parameter int Nbit     = 8,
  parameter int CLK_DIV  = 4,
  parameter int CS_SETUP = 4,
  parameter int ADR_GAP  = 4,
  parameter int CS_HOLD  = 2,
  parameter int CS_IDLE  = 4
) (
  input  logic              clk,
  input  logic              rst,
  spi_master_rw_if.master   bus
);

  localparam int TX_W   = CMD_W + Nbit;
  localparam int BCNT_W = max_int($clog2(Nbit + 1), $clog2(CMD_W + 1));

  if (CLK_DIV < MIN_CLK_DIV || CLK_DIV > MAX_CLK_DIV) begin : g_bad_clk_div
    $error("spi_master_rw: CLK_DIV must be in 4..255");
  end
  if (CS_SETUP < MIN_CS_SETUP) begin : g_bad_cs_setup
    $error("spi_master_rw: CS_SETUP must be at least 3");
  end
  if (ADR_GAP < MIN_ADR_GAP) begin : g_bad_adr_gap
    $error("spi_master_rw: ADR_GAP must be at least 3");
  end

  spi_state_e          state;
  logic [7:0]          cnt;
  logic [BCNT_W-1:0]   bit_cnt;
  logic                rw_q;
  logic                cs_q;
  logic                busy_q;
  logic                done_q;
  logic                mosi_q;
  logic [Nbit-1:0]     rdata_q;
  logic [Nbit-1:0]     rx_shift;
  logic [TX_W-1:0]     tx_shift;
  logic [CMD_W-1:0]    cmd_word;
  logic                accept;
  logic                sclk_en;
  logic                sclk;
  logic                rise_stb;
  logic                fall_stb;

  always_comb begin
    cmd_word                = '0;
    cmd_word[CMD_RW_BIT]    = bus.rw;
    cmd_word[ADR_W-1:0]     = bus.adr;
  end

  // busy is low only in IDLE, so this is "start while not busy"
  assign accept  = (state == ST_IDLE) && bus.start;
  assign sclk_en = (state == ST_CMD) || (state == ST_DATA);

  spi_sclk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_sclk_gen (
    .clk      (clk),
    .rst      (rst),
    .en       (sclk_en),
    .sclk     (sclk),
    .rise_stb (rise_stb),
    .fall_stb (fall_stb)
  );

  // Control FSM. SETUP lasts CS_SETUP+1 cycles: the cycle right after
  // acceptance plus CS_SETUP cycles of cs-low settle time.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ST_IDLE;
      cnt     <= 8'd0;
      bit_cnt <= '0;
      rw_q    <= 1'b0;
      cs_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      mosi_q  <= 1'b0;
      rdata_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            state  <= ST_SETUP;
            cnt    <= 8'd0;
            rw_q   <= bus.rw;
            cs_q   <= 1'b0;
            busy_q <= 1'b1;
            mosi_q <= bus.rw;
          end
        end
        ST_SETUP: begin
          if (cnt == 8'(CS_SETUP)) begin
            state   <= ST_CMD;
            bit_cnt <= '0;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        ST_CMD: begin
          // The 8th fall also presents the first data bit for GAP
          if (fall_stb) begin
            mosi_q <= tx_shift[TX_W-2];
            if (bit_cnt == BCNT_W'(CMD_W - 1)) begin
              state   <= ST_GAP;
              cnt     <= 8'd0;
              bit_cnt <= '0;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        ST_GAP: begin
          if (cnt == 8'(ADR_GAP - 1)) begin
            state <= ST_DATA;
            if (!rw_q) begin
              mosi_q <= 1'b0;
            end
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        ST_DATA: begin
          if (fall_stb) begin
            mosi_q <= rw_q ? tx_shift[TX_W-2] : 1'b0;
            if (bit_cnt == BCNT_W'(Nbit - 1)) begin
              state   <= ST_HOLD;
              cnt     <= 8'd0;
              bit_cnt <= '0;
              mosi_q  <= 1'b0;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        ST_HOLD: begin
          if (cnt == 8'(CS_HOLD - 1)) begin
            state  <= ST_IDLE_GAP;
            cnt    <= 8'd0;
            cs_q   <= 1'b1;
            done_q <= 1'b1;
            if (!rw_q) begin
              rdata_q <= rx_shift;
            end
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        ST_IDLE_GAP: begin
          if (cnt == 8'(CS_IDLE - 1)) begin
            state  <= ST_IDLE;
            busy_q <= 1'b0;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Shift registers: tx advances one bit per sclk fall; rx takes miso on
  // the edge where sclk goes high, MSB received first.
  always_ff @(posedge clk) begin
    if (accept) begin
      tx_shift <= {cmd_word, bus.wdata};
    end else if (fall_stb) begin
      tx_shift <= tx_shift << 1;
    end
    if ((state == ST_DATA) && rise_stb && !rw_q) begin
      rx_shift <= {rx_shift[Nbit-2:0], bus.miso};
    end
  end

  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.rdata = rdata_q;
  assign bus.sclk  = sclk;
  assign bus.mosi  = mosi_q;
  assign bus.cs    = cs_q;

endmodule

// File: tb/tb_spi_master_rw.sv
// Directed bench for spi_master_rw: two masters (8-bit/div 4 and 16-bit/div 6)
// each talking to a behavioural read-back slave at address 1.
module tb_spi_master_rw;
  import spi_pkg::*;

  localparam int BUDGET = 600;
  localparam logic [6:0] SLV_ADR = 7'd1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  spi_master_rw_if #(.Nbit(8))  if0 ();
  spi_master_rw_if #(.Nbit(16)) if1 ();

  spi_master_rw #(.Nbit(8), .CLK_DIV(4)) dut0 (
    .clk (clk),
    .rst (rst_n),
    .bus (if0)
  );

  spi_master_rw #(.Nbit(16), .CLK_DIV(6)) dut1 (
    .clk (clk),
    .rst (rst_n),
    .bus (if1)
  );

  // Behavioural slaves (index 0 -> inport 0xA5, index 1 -> inport 0xBEEF).
  // Sample mosi on sclk rise, shift miso on sclk fall; miso high unless
  // driving read data for a matching address.
  logic [1:0]  sl_sclk, sl_cs, sl_mosi;
  logic        s_sclk_d [2];
  int          s_cnt    [2];
  logic [7:0]  s_cmd    [2];
  logic [15:0] s_wr     [2];
  logic [15:0] s_sh     [2];
  logic        s_match  [2];
  logic        s_rd     [2];
  logic        s_miso   [2] = '{1'b1, 1'b1};

  assign sl_sclk  = {if1.sclk, if0.sclk};
  assign sl_cs    = {if1.cs, if0.cs};
  assign sl_mosi  = {if1.mosi, if0.mosi};
  assign if0.miso = s_miso[0];
  assign if1.miso = s_miso[1];

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (sl_cs[k]) begin
        s_cnt[k]  <= 0;
        s_miso[k] <= 1'b1;
        s_wr[k]   <= 16'h0;
      end else begin
        if (sl_sclk[k] && !s_sclk_d[k]) begin
          if (s_cnt[k] < 8) begin
            s_cmd[k] <= {s_cmd[k][6:0], sl_mosi[k]};
            if (s_cnt[k] == 7) begin
              s_match[k] <= ({s_cmd[k][5:0], sl_mosi[k]} == SLV_ADR);
              s_rd[k]    <= !s_cmd[k][6];
            end
          end else begin
            s_wr[k] <= {s_wr[k][14:0], sl_mosi[k]};
          end
          s_cnt[k] <= s_cnt[k] + 1;
        end
        if (!sl_sclk[k] && s_sclk_d[k] && s_cnt[k] >= 8) begin
          if (s_cnt[k] == 8) begin
            s_miso[k] <= (s_match[k] && s_rd[k]) ? (k != 0 ? 1'b1 : 1'b1) & (k != 0 ? 16'hBEEF >> 15 : 16'hA500 >> 15) : 1'b1;
            s_sh[k]   <= (k != 0) ? 16'hBEEF << 1 : 16'hA500 << 1;
          end else begin
            s_miso[k] <= (s_match[k] && s_rd[k]) ? s_sh[k][15] : 1'b1;
            s_sh[k]   <= s_sh[k] << 1;
          end
        end
      end
      s_sclk_d[k] <= sl_sclk[k];
    end
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic f_done(input int s);
    return (s != 0) ? if1.done : if0.done;
  endfunction
  function automatic logic f_busy(input int s);
    return (s != 0) ? if1.busy : if0.busy;
  endfunction
  function automatic logic f_cs(input int s);
    return (s != 0) ? if1.cs : if0.cs;
  endfunction
  function automatic logic [15:0] f_rdata(input int s);
    return (s != 0) ? if1.rdata : {8'h0, if0.rdata};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_start(input int s, input logic v);
    if (s != 0) if1.start = v;
    else        if0.start = v;
  endtask

  // Issue one request and wait for done; lat = edges from the start edge to
  // done (-1 if the budget expired), ndone = done pulses seen in that window.
  task automatic run_txn(input int s, input logic rw_i, input logic [6:0] adr_i,
                         input logic [15:0] wd_i, input bit inject,
                         output int lat, output int ndone);
    if (s != 0) begin
      if1.rw = rw_i; if1.adr = adr_i; if1.wdata = wd_i;
    end else begin
      if0.rw = rw_i; if0.adr = adr_i; if0.wdata = wd_i[7:0];
    end
    set_start(s, 1'b1);
    step();
    set_start(s, 1'b0);
    lat   = -1;
    ndone = 0;
    for (int n = 1; n <= BUDGET; n++) begin
      set_start(s, inject && (n == 10 || n == 100));
      step();
      if (f_done(s)) begin
        ndone++;
        lat = n;
        break;
      end
    end
    set_start(s, 1'b0);
  endtask

  initial begin
    int lat, nd, hi;
    if0.start = 0; if0.rw = 0; if0.adr = 0; if0.wdata = 0;
    if1.start = 0; if1.rw = 0; if1.adr = 0; if1.wdata = 0;
    repeat (3) step();

    // Reset state
    chk("rst_cs",    32'(if0.cs), 1);
    chk("rst_sclk",  32'(if0.sclk), 0);
    chk("rst_mosi",  32'(if0.mosi), 0);
    chk("rst_busy",  32'(if0.busy), 0);
    chk("rst_done",  32'(if0.done), 0);
    chk("rst_rdata", 32'(if0.rdata), 0);
    rst_n = 1'b1;
    repeat (2) step();

    // 1: read matching slave
    run_txn(0, 1'b0, 7'd1, 16'h0, 1'b0, lat, nd);
    chk("t1_lat",   32'(lat), 139);
    chk("t1_cmd",   32'(s_cmd[0]), 32'h01);
    chk("t1_mosi0", 32'(s_wr[0]), 32'h0);
    chk("t1_bits",  32'(s_cnt[0]), 16);
    chk("t1_rdata", 32'(f_rdata(0)), 32'hA5);
    step();
    chk("t1_done1", 32'(if0.done), 0);
    chk("t1_cs",    32'(if0.cs), 1);
    while (if0.busy) step();

    // 2: write, rdata must hold the previous read value
    run_txn(0, 1'b1, 7'h12, 16'h3C, 1'b0, lat, nd);
    chk("t2_lat",   32'(lat), 139);
    chk("t2_cmd",   32'(s_cmd[0]), 32'h92);
    chk("t2_data",  32'(s_wr[0]), 32'h3C);
    chk("t2_rdata", 32'(f_rdata(0)), 32'hA5);
    step();
    chk("t2_cs",    32'(if0.cs), 1);
    while (if0.busy) step();

    // 3: read absent address returns all ones
    run_txn(0, 1'b0, 7'd5, 16'h0, 1'b0, lat, nd);
    chk("t3_lat",   32'(lat), 139);
    chk("t3_cmd",   32'(s_cmd[0]), 32'h05);
    chk("t3_bits",  32'(s_cnt[0]), 16);
    chk("t3_rdata", 32'(f_rdata(0)), 32'hFF);
    while (if0.busy) step();

    // 4: start pulses while busy are ignored
    run_txn(0, 1'b0, 7'd1, 16'h0, 1'b1, lat, nd);
    chk("t4_lat", 32'(lat), 139);
    if0.start = 1'b1;
    step();
    if0.start = 1'b0;
    chk("t4_gap_busy", 32'(if0.busy), 1);
    for (int n = 0; n < 20 && if0.busy; n++) begin
      step();
      if (if0.done) nd++;
    end
    chk("t4_ndone", 32'(nd), 1);
    chk("t4_idle",  32'(if0.busy), 0);
    step();
    chk("t4_noqueue_cs",   32'(if0.cs), 1);
    chk("t4_noqueue_busy", 32'(if0.busy), 0);
    run_txn(0, 1'b0, 7'd1, 16'h0, 1'b0, lat, nd);
    chk("t4_next_lat", 32'(lat), 139);
    while (if0.busy) step();

    // 5: asynchronous reset mid-read
    if0.rw = 1'b0; if0.adr = 7'd1;
    if0.start = 1'b1;
    step();
    if0.start = 1'b0;
    repeat (49) step();
    chk("t5_pre_cs", 32'(if0.cs), 0);
    rst_n = 1'b0;
    #1;
    chk("t5_cs",    32'(if0.cs), 1);
    chk("t5_sclk",  32'(if0.sclk), 0);
    chk("t5_busy",  32'(if0.busy), 0);
    chk("t5_rdata", 32'(if0.rdata), 0);
    repeat (2) step();
    rst_n = 1'b1;
    repeat (2) step();
    run_txn(0, 1'b0, 7'd1, 16'h0, 1'b0, lat, nd);
    chk("t5_lat",   32'(lat), 139);
    chk("t5_rdata_after", 32'(f_rdata(0)), 32'hA5);

    // 6: 16-bit master, back-to-back reads
    run_txn(1, 1'b0, 7'd1, 16'h0, 1'b0, lat, nd);
    chk("t6a_lat",   32'(lat), 299);
    chk("t6a_bits",  32'(s_cnt[1]), 24);
    chk("t6a_rdata", 32'(f_rdata(1)), 32'hBEEF);
    hi = 1;
    for (int n = 0; n < 20 && f_busy(1); n++) begin
      step();
      if (f_cs(1)) hi++;
    end
    chk("t6_idle", 32'(f_busy(1)), 0);
    chk("t6_cs_gap", 32'(hi >= 4), 1);
    run_txn(1, 1'b0, 7'd1, 16'h0, 1'b0, lat, nd);
    chk("t6b_lat",   32'(lat), 299);
    chk("t6b_rdata", 32'(f_rdata(1)), 32'hBEEF);
    step();
    chk("t6b_cs", 32'(f_cs(1)), 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
